// File: rtl/led_ctrl_pkg.sv
// Shared constants and FSM encoding for the LED flasher control path.
package led_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLASH = 1'b1
    } state_e;

    // Default cycle counts at 50 MHz.
    localparam int unsigned DEBOUNCE_CYC_DEF     = 1_000_000;
    localparam int unsigned AUTO_OFF_CYC_DEF     = 250_000_000;
    localparam int unsigned FLASH_PERIOD_CYC_DEF = 25_000_000;

endpackage

// File: rtl/key_flash_ctrl_if.sv
// Button in, debounced press pulse and flash-enable level out.
interface key_flash_ctrl_if;
    logic key_in;
    logic key_press;
    logic valid;

    modport master (output key_in, input key_press, input valid);
    modport slave (input key_in, output key_press, output valid);
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser, counter debouncer and press-edge detector for an active-low key.
module key_debounce
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_press
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

    logic [1:0]      sync_q;
    logic [1:0]      fill_q;
    logic            key_s;
    logic [CntW-1:0] db_cnt_q, db_cnt_d;
    logic            key_db_q, key_db_d;
    logic            key_db_dly_q;
    logic            armed_q, armed_d;
    logic            key_press_q, key_press_d;

    assign key_s     = sync_q[1];
    assign key_press = key_press_q;

    always_comb begin
        db_cnt_d = '0;
        key_db_d = key_db_q;
        if (key_s != key_db_q) begin
            if (db_cnt_q == CntMax) key_db_d = key_s;
            else                    db_cnt_d = db_cnt_q + CntW'(1);
        end
        // Presses count only once the key has been seen released after reset,
        // so a key held through reset release never fires.
        armed_d     = armed_q | (fill_q[1] & key_s & key_db_q);
        key_press_d = armed_q & key_db_dly_q & ~key_db_q;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= 2'b11;
            fill_q       <= 2'b00;
            db_cnt_q     <= '0;
            key_db_q     <= 1'b1;
            key_db_dly_q <= 1'b1;
            armed_q      <= 1'b0;
            key_press_q  <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], key_in};
            fill_q       <= {fill_q[0], 1'b1};
            db_cnt_q     <= db_cnt_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
            armed_q      <= armed_d;
            key_press_q  <= key_press_d;
        end
    end

endmodule

// File: rtl/key_flash_ctrl.sv
// Toggles the flash enable on each debounced key press.
// Define AUTO_OFF_EN to stop flashing automatically after AUTO_OFF_CYC cycles.
module key_flash_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int unsigned AUTO_OFF_CYC = AUTO_OFF_CYC_DEF
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    key_flash_ctrl_if.slave bus
);
    state_e state_q, state_d;
    logic   key_press;
    logic   timeout;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .key_in   (bus.key_in),
        .key_press(key_press)
    );

`ifdef AUTO_OFF_EN
    localparam int unsigned OnW = $clog2(AUTO_OFF_CYC + 1);
    localparam logic [OnW-1:0] OnMax = OnW'(AUTO_OFF_CYC - 1);

    logic [OnW-1:0] on_cnt_q, on_cnt_d;

    assign timeout = (state_q == ST_FLASH) && (on_cnt_q == OnMax);

    always_comb begin
        on_cnt_d = '0;
        if (state_q == ST_FLASH && !timeout) on_cnt_d = on_cnt_q + OnW'(1);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) on_cnt_q <= '0;
        else        on_cnt_q <= on_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (key_press)            state_d = ST_FLASH;
            ST_FLASH: if (key_press || timeout) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign bus.valid     = (state_q == ST_FLASH);
    assign bus.key_press = key_press;

endmodule
